// File: rtl/csr_ctrl_pkg.sv
// Shared constants and types for the CSR instruction sequencer.
package csr_ctrl_pkg;

  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  localparam logic [11:0] MSTATUS = 12'h300;
  localparam logic [11:0] MTVEC   = 12'h305;
  localparam logic [11:0] MEPC    = 12'h341;
  localparam logic [11:0] MCAUSE  = 12'h342;
  localparam logic [11:0] MCYCLE  = 12'hB00;
  localparam logic [11:0] MCYCLEH = 12'hB80;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  typedef enum logic [1:0] {OP_NOP, OP_CSR, OP_ECALL, OP_MRET} op_kind_t;

  // ecall wins over mret; funct3 x00 without either flag is a no-op.
  function automatic op_kind_t decode_kind(input logic [2:0] funct3,
                                           input logic is_ecall,
                                           input logic is_mret);
    if (is_ecall)                 return OP_ECALL;
    else if (is_mret)             return OP_MRET;
    else if (funct3[1:0] != 2'b00) return OP_CSR;
    else                          return OP_NOP;
  endfunction

endpackage

// File: rtl/csr_ctrl_alu.sv
// Combinational CSR read-modify-write: old value, source and funct3 -> new value.
module csr_alu
  import csr_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] src,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] new_val
);

  always_comb begin
    new_val = old_val;
    case (funct3)
      CSRRW, CSRRWI: new_val = src;
      CSRRS, CSRRSI: new_val = old_val | src;
      CSRRC, CSRRCI: new_val = old_val & ~src;
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_ctrl.sv
// Multi-cycle CSR/SYSTEM instruction sequencer (IDLE->READ->WRITE->RESP).
// Optional local 64-bit mcycle counter at 0xB00/0xB80 under `CSR_CTRL_MCYCLE_EN.
module csr_ctrl
  import csr_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [11:0]     in_csr_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [4:0]      in_zimm,
  input  logic [4:0]      in_rd,
  input  logic            in_is_ecall,
  input  logic            in_is_mret,
  input  logic [XLEN-1:0] in_pc,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            csr_we,
  output logic            csr_ecall,
  output logic [XLEN-1:0] csr_pc,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_rd_wdata,
  output logic            out_redirect,
  output logic [XLEN-1:0] out_redirect_pc
);

  state_t          state, state_next;
  op_kind_t        kind_q;
  logic [2:0]      funct3_q;
  logic [11:0]     addr_q;
  logic [XLEN-1:0] rs1_q, pc_q, old_q, new_q, redir_pc_q;
  logic [4:0]      zimm_q, rd_q;
  logic [XLEN-1:0] src, old_src, alu_new;
  logic            wr_req, local_hit;

  assign src    = funct3_q[2] ? XLEN'(zimm_q) : rs1_q;
  // Set/clear forms write only when the rs1 field is nonzero.
  assign wr_req = (kind_q == OP_CSR) && ((funct3_q[1:0] == 2'b01) || (zimm_q != '0));

`ifdef CSR_CTRL_MCYCLE_EN
  logic [63:0] mcycle_q;

  // Served locally; the CSR file only decodes the low address byte.
  assign local_hit = (addr_q == MCYCLE) || (addr_q == MCYCLEH);

  always_comb begin
    old_src = csr_rdata;
    if (addr_q == MCYCLE)       old_src = XLEN'(mcycle_q[31:0]);
    else if (addr_q == MCYCLEH) old_src = XLEN'(mcycle_q[63:32]);
  end

  always_ff @(posedge clk) begin
    if (rst)
      mcycle_q <= '0;
    else if (state == WRITE && wr_req && addr_q == MCYCLE)
      mcycle_q[31:0] <= new_q[31:0];
    else if (state == WRITE && wr_req && addr_q == MCYCLEH)
      mcycle_q[63:32] <= new_q[31:0];
    else
      mcycle_q <= mcycle_q + 64'd1;
  end
`else
  assign local_hit = 1'b0;
  assign old_src   = csr_rdata;
`endif

  csr_alu #(.XLEN(XLEN)) u_alu (
    .old_val (old_src),
    .src     (src),
    .funct3  (funct3_q),
    .new_val (alu_new)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Strobes are gated by rst so a reset in WRITE never reaches the CSR file.
  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    csr_we       = 1'b0;
    csr_ecall    = 1'b0;
    out_valid    = 1'b0;
    out_rd_we    = 1'b0;
    out_redirect = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = READ;
      end
      READ: state_next = WRITE;
      WRITE: begin
        csr_we     = wr_req && !local_hit && !rst;
        csr_ecall  = (kind_q == OP_ECALL) && !rst;
        state_next = RESP;
      end
      RESP: begin
        out_valid    = 1'b1;
        out_rd_we    = (kind_q == OP_CSR) && (rd_q != '0);
        out_redirect = (kind_q == OP_ECALL) || (kind_q == OP_MRET);
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q     <= OP_NOP;
      funct3_q   <= '0;
      addr_q     <= '0;
      rs1_q      <= '0;
      zimm_q     <= '0;
      rd_q       <= '0;
      pc_q       <= '0;
      old_q      <= '0;
      new_q      <= '0;
      redir_pc_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          kind_q   <= decode_kind(in_funct3, in_is_ecall, in_is_mret);
          funct3_q <= in_funct3;
          addr_q   <= in_csr_addr;
          rs1_q    <= in_rs1_data;
          zimm_q   <= in_zimm;
          rd_q     <= in_rd;
          pc_q     <= in_pc;
        end
        READ: begin
          old_q <= (kind_q == OP_CSR) ? old_src : '0;
          new_q <= alu_new;
        end
        WRITE: redir_pc_q <= (kind_q == OP_ECALL) ? csr_mtvec :
                             (kind_q == OP_MRET)  ? csr_mepc  : '0;
        default: ;
      endcase
    end
  end

  assign csr_addr        = addr_q;
  assign csr_wdata       = new_q;
  assign csr_pc          = pc_q;
  assign out_rd          = rd_q;
  assign out_rd_wdata    = old_q;
  assign out_redirect_pc = redir_pc_q;

endmodule

// File: tb/tb_csr_ctrl.sv
// Scoreboard testbench for csr_ctrl; CSR file modelled as a few bench-owned registers.
module tb_csr_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [2:0]  in_funct3 = '0;
  logic [11:0] in_csr_addr = '0;
  logic [31:0] in_rs1_data = '0, in_pc = '0;
  logic [4:0]  in_zimm = '0, in_rd = '0;
  logic        in_is_ecall = 1'b0, in_is_mret = 1'b0;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_pc, csr_rdata, csr_mtvec, csr_mepc;
  logic        csr_we, csr_ecall;
  logic        out_valid, out_ready = 1'b1, out_rd_we, out_redirect;
  logic [4:0]  out_rd;
  logic [31:0] out_rd_wdata, out_redirect_pc;

  logic [31:0] m_mstatus = '0, m_mtvec = '0, m_mepc = '0;

  always #5 clk = ~clk;

  always_comb begin
    case (csr_addr)
      12'h300: csr_rdata = m_mstatus;
      12'h305: csr_rdata = m_mtvec;
      12'h341: csr_rdata = m_mepc;
      default: csr_rdata = 32'h0;
    endcase
  end
  assign csr_mtvec = m_mtvec;
  assign csr_mepc  = m_mepc;

  csr_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
    .in_csr_addr(in_csr_addr), .in_rs1_data(in_rs1_data), .in_zimm(in_zimm),
    .in_rd(in_rd), .in_is_ecall(in_is_ecall), .in_is_mret(in_is_mret), .in_pc(in_pc),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_we(csr_we), .csr_ecall(csr_ecall),
    .csr_pc(csr_pc), .csr_rdata(csr_rdata), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_rd_wdata(out_rd_wdata), .out_redirect(out_redirect), .out_redirect_pc(out_redirect_pc)
  );

  typedef struct {
    int          we_cnt;
    logic [31:0] wdata;
    int          ecall_cnt;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_we;
    logic [31:0] rd_wdata;
    logic        redir;
    logic [31:0] redir_pc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0, failures = 0;

  int          ob_we_cnt, ob_we_cyc, ob_ecall_cnt, ob_ecall_cyc, ob_lat;
  logic [31:0] ob_we_data, ob_pc;
  logic        ob_both;

  function automatic logic [149:0] all_outs();
    return {csr_we, csr_ecall, csr_addr, csr_wdata, csr_pc, out_valid, out_rd,
            out_rd_we, out_rd_wdata, out_redirect, out_redirect_pc};
  endfunction

  // Called at a negedge while idle; returns at the negedge of the READ cycle.
  task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                       input logic [4:0] zimm, input logic [4:0] rd,
                       input logic ec, input logic mr, input logic [31:0] pc);
    in_valid = 1'b1; in_funct3 = f3; in_csr_addr = a; in_rs1_data = rs1;
    in_zimm = zimm; in_rd = rd; in_is_ecall = ec; in_is_mret = mr; in_pc = pc;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Records strobes cycle by cycle until out_valid or a 10-cycle bound.
  task automatic observe();
    ob_we_cnt = 0; ob_we_cyc = 0; ob_ecall_cnt = 0; ob_ecall_cyc = 0; ob_lat = 0;
    ob_we_data = '0; ob_pc = '0; ob_both = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (csr_we) begin ob_we_cnt++; ob_we_cyc = i; ob_we_data = csr_wdata; end
      if (csr_ecall) begin ob_ecall_cnt++; ob_ecall_cyc = i; ob_pc = csr_pc; end
      if (csr_we && csr_ecall) ob_both = 1'b1;
      if (out_valid) begin ob_lat = i; break; end
      @(negedge clk);
    end
  endtask

  task automatic retire();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (all_outs() !== '0) begin failures++; $display("FAIL reset_outputs: got %h expected 0", all_outs()); end
    rst = 1'b0;
  endtask

  task automatic test_csrrw();
    m_mtvec = 32'h0;
    sb.push_back('{1, 32'h8000_0100, 0, 32'h0, 5'd5, 1'b1, 32'h0, 1'b0, 32'h0});
    issue(3'b001, 12'h305, 32'h8000_0100, 5'd1, 5'd5, 1'b0, 1'b0, 32'h0);
    observe();
    e = sb.pop_front();
    checks++; if (ob_we_cnt !== e.we_cnt || ob_we_cyc !== 2) begin failures++; $display("FAIL csrrw_we: got count %0d cycle %0d expected count %0d cycle 2", ob_we_cnt, ob_we_cyc, e.we_cnt); end
    checks++; if (ob_we_data !== e.wdata) begin failures++; $display("FAIL csrrw_wdata: got %h expected %h", ob_we_data, e.wdata); end
    checks++; if (ob_lat !== 3) begin failures++; $display("FAIL csrrw_latency: got %0d expected 3", ob_lat); end
    checks++; if ({out_rd, out_rd_we, out_rd_wdata, out_redirect} !== {e.rd, e.rd_we, e.rd_wdata, e.redir}) begin
      failures++; $display("FAIL csrrw_resp: got rd=%0d we=%b data=%h redir=%b expected rd=%0d we=%b data=%h redir=%b",
                           out_rd, out_rd_we, out_rd_wdata, out_redirect, e.rd, e.rd_we, e.rd_wdata, e.redir); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL csrrw_busy_ready: got %b expected 0", in_ready); end
    retire();
    m_mtvec = 32'h8000_0100;
  endtask

  task automatic test_csrrs_x0();
    m_mstatus = 32'h1800;
    sb.push_back('{0, 32'h0, 0, 32'h0, 5'd0, 1'b0, 32'h1800, 1'b0, 32'h0});
    issue(3'b010, 12'h300, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    observe();
    e = sb.pop_front();
    checks++; if (ob_we_cnt !== e.we_cnt) begin failures++; $display("FAIL csrrs_x0_we: got %0d expected %0d", ob_we_cnt, e.we_cnt); end
    checks++; if (ob_lat !== 3) begin failures++; $display("FAIL csrrs_x0_latency: got %0d expected 3", ob_lat); end
    checks++; if (out_rd_we !== e.rd_we || out_rd_wdata !== e.rd_wdata) begin failures++; $display("FAIL csrrs_x0_resp: got we=%b data=%h expected we=%b data=%h", out_rd_we, out_rd_wdata, e.rd_we, e.rd_wdata); end
    retire();
  endtask

  task automatic test_csrrci();
    m_mstatus = 32'h1808;
    sb.push_back('{1, 32'h1800, 0, 32'h0, 5'd3, 1'b1, 32'h1808, 1'b0, 32'h0});
    issue(3'b111, 12'h300, 32'hFFFF_FFFF, 5'd8, 5'd3, 1'b0, 1'b0, 32'h0);
    observe();
    e = sb.pop_front();
    checks++; if (ob_we_cnt !== e.we_cnt || ob_we_data !== e.wdata) begin failures++; $display("FAIL csrrci_write: got count %0d data %h expected count %0d data %h", ob_we_cnt, ob_we_data, e.we_cnt, e.wdata); end
    checks++; if (out_rd !== e.rd || out_rd_we !== e.rd_we || out_rd_wdata !== e.rd_wdata) begin failures++; $display("FAIL csrrci_resp: got rd=%0d we=%b data=%h expected rd=%0d we=%b data=%h", out_rd, out_rd_we, out_rd_wdata, e.rd, e.rd_we, e.rd_wdata); end
    retire();
    m_mstatus = 32'h1800;
  endtask

  task automatic test_ecall(input logic also_mret);
    m_mtvec = 32'h8000_0200;
    m_mepc  = 32'h1234_5678;
    sb.push_back('{0, 32'h0, 1, 32'h8000_0040, 5'd0, 1'b0, 32'h0, 1'b1, 32'h8000_0200});
    issue(3'b000, 12'h000, 32'h0, 5'd0, 5'd0, 1'b1, also_mret, 32'h8000_0040);
    observe();
    e = sb.pop_front();
    checks++; if (ob_ecall_cnt !== e.ecall_cnt || ob_ecall_cyc !== 2 || ob_pc !== e.pc) begin failures++; $display("FAIL ecall_pulse(mret=%b): got count %0d cycle %0d pc %h expected count %0d cycle 2 pc %h", also_mret, ob_ecall_cnt, ob_ecall_cyc, ob_pc, e.ecall_cnt, e.pc); end
    checks++; if (ob_we_cnt !== e.we_cnt || ob_both !== 1'b0) begin failures++; $display("FAIL ecall_no_we(mret=%b): got %0d expected %0d", also_mret, ob_we_cnt, e.we_cnt); end
    checks++; if (out_redirect !== e.redir || out_redirect_pc !== e.redir_pc || out_rd_we !== e.rd_we) begin failures++; $display("FAIL ecall_resp(mret=%b): got redir=%b pc=%h rd_we=%b expected redir=%b pc=%h rd_we=%b", also_mret, out_redirect, out_redirect_pc, out_rd_we, e.redir, e.redir_pc, e.rd_we); end
    retire();
  endtask

  task automatic test_mret_stall();
    m_mepc = 32'h8000_0044;
    out_ready = 1'b0;
    sb.push_back('{0, 32'h0, 0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1, 32'h8000_0044});
    issue(3'b000, 12'h000, 32'h0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h8000_0050);
    observe();
    e = sb.pop_front();
    checks++; if (ob_we_cnt !== 0 || ob_ecall_cnt !== 0 || ob_lat !== 3) begin failures++; $display("FAIL mret_strobes: got we=%0d ecall=%0d lat=%0d expected 0 0 3", ob_we_cnt, ob_ecall_cnt, ob_lat); end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_redirect !== e.redir || out_redirect_pc !== e.redir_pc || in_ready !== 1'b0 || out_rd_we !== 1'b0) begin
        failures++; $display("FAIL mret_hold_%0d: got valid=%b redir=%b pc=%h in_ready=%b expected 1 1 %h 0", c, out_valid, out_redirect, out_redirect_pc, in_ready, e.redir_pc);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    retire();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL mret_release: got valid=%b in_ready=%b expected 0 1", out_valid, in_ready); end
  endtask

  task automatic test_nop(input logic [2:0] f3);
    sb.push_back('{0, 32'h0, 0, 32'h0, 5'd7, 1'b0, 32'h0, 1'b0, 32'h0});
    issue(f3, 12'h300, 32'h55, 5'd3, 5'd7, 1'b0, 1'b0, 32'h100);
    observe();
    e = sb.pop_front();
    checks++; if (ob_we_cnt !== 0 || ob_ecall_cnt !== 0 || ob_lat !== 3) begin failures++; $display("FAIL nop_%b_strobes: got we=%0d ecall=%0d lat=%0d expected 0 0 3", f3, ob_we_cnt, ob_ecall_cnt, ob_lat); end
    checks++; if (out_rd_we !== e.rd_we || out_redirect !== e.redir) begin failures++; $display("FAIL nop_%b_resp: got rd_we=%b redir=%b expected 0 0", f3, out_rd_we, out_redirect); end
    retire();
  endtask

  task automatic test_ignore_busy_input();
    m_mepc = 32'h11;
    sb.push_back('{1, 32'hAA, 0, 32'h0, 5'd6, 1'b1, 32'h11, 1'b0, 32'h0});
    issue(3'b001, 12'h341, 32'hAA, 5'd1, 5'd6, 1'b0, 1'b0, 32'h0);
    in_valid = 1'b1; in_rd = 5'd9; in_csr_addr = 12'h300; in_rs1_data = 32'hBB;
    observe();
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++; if (ob_we_cnt !== e.we_cnt || ob_we_data !== e.wdata) begin failures++; $display("FAIL busy_ignore_write: got count %0d data %h expected count %0d data %h", ob_we_cnt, ob_we_data, e.we_cnt, e.wdata); end
    checks++; if (out_rd !== e.rd || out_rd_wdata !== e.rd_wdata) begin failures++; $display("FAIL busy_ignore_resp: got rd=%0d data=%h expected rd=%0d data=%h", out_rd, out_rd_wdata, e.rd, e.rd_wdata); end
    retire();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL busy_ignore_idle: got in_ready=%b valid=%b expected 1 0", in_ready, out_valid); end
  endtask

  task automatic test_reset_mid();
    issue(3'b001, 12'h300, 32'hDEAD, 5'd1, 5'd4, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (csr_we !== 1'b0 || csr_ecall !== 1'b0) begin failures++; $display("FAIL reset_mid_strobe: got we=%b ecall=%b expected 0 0", csr_we, csr_ecall); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || all_outs() !== '0) begin failures++; $display("FAIL reset_mid_state: got in_ready=%b outs=%h expected 1 and 0", in_ready, all_outs()); end
    rst = 1'b0;
  endtask

`ifdef CSR_CTRL_MCYCLE_EN
  // Entered at the negedge where rst was released.
  task automatic test_mcycle();
    repeat (4) @(negedge clk);
    issue(3'b010, 12'hB00, 32'h0, 5'd0, 5'd2, 1'b0, 1'b0, 32'h0);
    observe();
    checks++; if (out_rd_wdata !== 32'd5 || ob_we_cnt !== 0) begin failures++; $display("FAIL mcycle_read: got %0d we=%0d expected 5 we=0", out_rd_wdata, ob_we_cnt); end
    retire();
    issue(3'b001, 12'hB80, 32'h12, 5'd1, 5'd0, 1'b0, 1'b0, 32'h0);
    observe();
    checks++; if (ob_we_cnt !== 0) begin failures++; $display("FAIL mcycleh_write_we: got %0d expected 0", ob_we_cnt); end
    retire();
    issue(3'b010, 12'hB80, 32'h0, 5'd0, 5'd2, 1'b0, 1'b0, 32'h0);
    observe();
    checks++; if (out_rd_wdata !== 32'h12) begin failures++; $display("FAIL mcycleh_readback: got %h expected 00000012", out_rd_wdata); end
    retire();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_csrrw();
    test_csrrs_x0();
    test_csrrci();
    test_ecall(1'b0);
    test_ecall(1'b1);
    test_mret_stall();
    test_nop(3'b100);
    test_nop(3'b000);
    test_ignore_busy_input();
    test_reset_mid();
`ifdef CSR_CTRL_MCYCLE_EN
    test_mcycle();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
